binary_row_packer: RTL and testbench
====================================

// Module: binary_row_packer
// PURPOSE
//   Writer-side companion to the 3x3 binary window stage: collects the 1-bit edge/morphology
//   pixel stream (pixel_valid/pixel_in, raster order, no back-pressure) and packs it into
//   bytes, 8 pixels per byte, for DMA/UART/PSRAM output.
//   - Rows are byte-aligned; a partial last byte in a row is zero-padded.
//   - A small FIFO absorbs the valid/ready stall on the byte side.
//   - Row and frame boundaries are tagged on every output byte.
// PARAMETERS
//   IMG_WIDTH   640  pixels per row (>=1)
//   IMG_HEIGHT  480  rows per frame (>=1)
//   FIFO_DEPTH  4    output byte FIFO entries (power of 2, >=2)
//   MSB_FIRST   1    1: first pixel of a byte -> bit7; 0: first pixel -> bit0
// PORTS
//   clk             in   1  system clock
//   rst_n           in   1  synchronous reset, active-low
//   frame_start     in   1  1-cycle pulse: restart pixel/row counters for a new frame
//   pixel_valid     in   1  pixel_in qualifier; no ready, a pixel is never held off
//   pixel_in        in   1  binary pixel
//   byte_valid      out  1  byte_data/tags valid
//   byte_ready      in   1  consumer accepts when byte_valid&&byte_ready
//   byte_data       out  8  packed pixels
//   byte_row_last   out  1  byte holds the last pixel of a row
//   byte_frame_last out  1  byte holds the last pixel of the frame (implies byte_row_last)
//   overflow        out  1  sticky: a packed byte was dropped because the FIFO was full
// BEHAVIOUR
//   Reset (rst_n==0 at a clk edge):
//     - col, row and bit counters = 0; shift register cleared; partial byte discarded.
//     - FIFO emptied. Outputs: byte_valid=0, byte_data=0, byte_row_last=0,
//       byte_frame_last=0, overflow=0.
//     - Reset mid-frame discards all pending data, with no flush.
//   Packing:
//     - Each accepted pixel is shifted into bit position bit_cnt (ordering per MSB_FIRST).
//     - col increments per pixel. The byte closes when bit_cnt==7 or col==IMG_WIDTH-1.
//     - A closing pixel at edge N writes the assembled byte (including that pixel) into the
//       FIFO at edge N. Unused bits in a row-end byte are 0. bit_cnt then returns to 0.
//     - Bytes per row = ceil(IMG_WIDTH/8).
//   Counters:
//     - col wraps IMG_WIDTH-1 -> 0 and then row increments.
//     - At row==IMG_HEIGHT-1 && col==IMG_WIDTH-1 the byte gets frame_last and row wraps to 0.
//   frame_start:
//     - Clears col, row, bit_cnt, the shift register and overflow. Bytes already in the
//       FIFO are kept and drain normally.
//     - If pixel_valid is high in the same cycle, that pixel is frame pixel (0,0).
//   Output side (first-word-fall-through):
//     - byte_valid = FIFO not empty. byte_data and tags come from the head entry.
//     - Latency: byte_valid rises in the cycle after edge N when the FIFO was empty.
//     - While byte_valid=1 && byte_ready=0, byte_data and the tags hold stable.
//     - Pop on byte_valid&&byte_ready. byte_ready while empty is ignored.
//   Full/empty:
//     - A push is accepted if the FIFO is not full, or if a pop happens in the same cycle
//       (simultaneous push+pop on a full FIFO keeps it full, with no loss).
//     - A push on a full FIFO with no pop drops that byte and sets overflow=1.
//       Counters still advance, so row/frame alignment is preserved.
//     - overflow clears only on rst_n or frame_start.
//   Widths:
//     - col: $clog2(IMG_WIDTH) bits; row: $clog2(IMG_HEIGHT) bits; bit_cnt: 3 bits.
//     - FIFO pointers are $clog2(FIFO_DEPTH)+1 bits wide.
//     - Each FIFO entry is 10 bits: data plus 2 tags.
// TESTING
//   1) W=16,H=2, MSB_FIRST=1, ready=1, pixels 1,0,1,0... -> 4 bytes 0xAA each.
//      frame_last only on byte 4. Each byte_valid 1 cycle after its 8th pixel.
//   2) W=10,H=1, all-ones, ready=1 -> 0xFF (row_last=0), then 0xC0 (row_last=1, frame_last=1).
//      With MSB_FIRST=0 -> 0xFF, then 0x03.
//   3) W=8, FIFO_DEPTH=4, ready=0, 40 ones ->
//      - bytes 1-4 are held with byte_data stable;
//      - byte 5 is dropped and overflow=1;
//      - then raise ready: exactly 4 0xFF bytes are popped, and overflow stays 1 until frame_start.
//   4) FIFO full, ready=1, with push and pop in the same cycle -> no drop, overflow stays 0,
//      byte order is preserved.
//   5) frame_start after 3 pixels of a row:
//      - the partial byte is discarded;
//      - the next 8 pixels form byte 0 of row 0;
//      - earlier FIFO bytes still drain first.
//   6) Assert rst_n=0 for 1 cycle with 2 bytes queued and a partial byte pending ->
//      next cycle byte_valid=0, overflow=0, and the next pixel lands at (0,0) bit7.

Source files
------------

// File: rtl/binary_row_packer_if.sv
// Pixel-in / byte-out bus of the binary row packer.
// The packer uses the slave modport; the pixel source and byte consumer use the master modport.
interface binary_row_packer_if;
    logic       frame_start;
    logic       pixel_valid;
    logic       pixel_in;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] byte_data;
    logic       byte_row_last;
    logic       byte_frame_last;
    logic       overflow;

    modport master (
        output frame_start, pixel_valid, pixel_in, byte_ready,
        input  byte_valid, byte_data, byte_row_last, byte_frame_last, overflow
    );

    modport slave (
        input  frame_start, pixel_valid, pixel_in, byte_ready,
        output byte_valid, byte_data, byte_row_last, byte_frame_last, overflow
    );
endinterface

// File: rtl/binary_row_packer.sv
// Packs a raster 1-bit pixel stream into byte-aligned row bytes tagged with row/frame ends.
// The bytes go through a small first-word-fall-through FIFO that drops bytes when full.
module binary_row_packer #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    binary_row_packer_if.slave  bus
);
    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic [9:0]    r_fifo [FIFO_DEPTH];
    logic [PW:0]   r_wr_ptr;
    logic [PW:0]   r_rd_ptr;
    logic          r_overflow;

    logic [CW-1:0] w_col_cur;
    logic [RW-1:0] w_row_cur;
    logic [2:0]    w_bit_cur;
    logic [2:0]    w_pos;
    logic [7:0]    w_shift_base;
    logic [7:0]    w_byte;
    logic          w_col_last;
    logic          w_frame_last;
    logic          w_close;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [9:0]    w_head;

    function automatic logic [7:0] place_bit(input logic [7:0] base, input logic p,
                                             input logic [2:0] pos);
        return base | (8'(p) << pos);
    endfunction

    // frame_start makes a same-cycle pixel land at (0,0) with an empty partial byte
    always_comb begin
        w_col_cur    = bus.frame_start ? '0 : r_col;
        w_row_cur    = bus.frame_start ? '0 : r_row;
        w_bit_cur    = bus.frame_start ? 3'd0 : r_bit_cnt;
        w_shift_base = bus.frame_start ? 8'd0 : r_shift;
        w_pos        = (MSB_FIRST != 0) ? (3'd7 - w_bit_cur) : w_bit_cur;
        w_byte       = place_bit(w_shift_base, bus.pixel_in, w_pos);
        w_col_last   = (w_col_cur == COL_MAX);
        w_frame_last = w_col_last && (w_row_cur == ROW_MAX);
        w_close      = bus.pixel_valid && ((w_bit_cur == 3'd7) || w_col_last);
        w_empty      = (r_wr_ptr == r_rd_ptr);
        w_full       = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                       (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
        w_pop        = !w_empty && bus.byte_ready;
        w_push       = w_close && (!w_full || w_pop);
        w_drop       = w_close && w_full && !w_pop;
        w_head       = w_empty ? 10'd0 : r_fifo[r_rd_ptr[PW-1:0]];
    end

    assign bus.byte_valid      = !w_empty;
    assign bus.byte_data       = w_head[7:0];
    assign bus.byte_row_last   = w_head[8];
    assign bus.byte_frame_last = w_head[9];
    assign bus.overflow        = r_overflow;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col     <= '0;
            r_row     <= '0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
        end else if (bus.pixel_valid) begin
            r_bit_cnt <= w_close ? 3'd0 : (w_bit_cur + 3'd1);
            r_shift   <= w_close ? 8'd0 : w_byte;
            r_col     <= w_col_last ? '0 : (w_col_cur + 1'b1);
            if (!w_col_last)
                r_row <= w_row_cur;
            else
                r_row <= (w_row_cur == ROW_MAX) ? '0 : (w_row_cur + 1'b1);
        end else if (bus.frame_start) begin
            r_col     <= '0;
            r_row     <= '0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
        end
    end

    // Dropped bytes still advance the counters above, so tags stay aligned
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_drop)
                r_overflow <= 1'b1;
            else if (bus.frame_start)
                r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wr_ptr[PW-1:0]] <= {w_frame_last, w_col_last, w_byte};
    end
endmodule

// File: tb/tb_binary_row_packer.sv
// Bench for binary_row_packer: MSB-first and LSB-first instances (10x2 image, 4-deep FIFO)
// share one stimulus stream; a monitor pops expected bytes from per-instance queues.
module tb_binary_row_packer;
    localparam int W = 10;
    localparam int H = 2;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    binary_row_packer_if bif_m ();
    binary_row_packer_if bif_l ();

    assign bif_l.frame_start = bif_m.frame_start;
    assign bif_l.pixel_valid = bif_m.pixel_valid;
    assign bif_l.pixel_in    = bif_m.pixel_in;
    assign bif_l.byte_ready  = bif_m.byte_ready;

    binary_row_packer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(D), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .bus(bif_m)
    );
    binary_row_packer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(D), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .bus(bif_l)
    );

    typedef logic [9:0] ent_t;
    ent_t q_m[$];
    ent_t q_l[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected byte for MSB-first instance, LSB-first instance, then row_last/frame_last tags
    task automatic expect_b(input logic [7:0] dm, input logic [7:0] dl, input logic rl,
                            input logic fl);
        q_m.push_back({fl, rl, dm});
        q_l.push_back({fl, rl, dl});
    endtask

    task automatic monitor();
        logic hold;
        ent_t held, act_m, act_l, e;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            act_m = {bif_m.byte_frame_last, bif_m.byte_row_last, bif_m.byte_data};
            act_l = {bif_l.byte_frame_last, bif_l.byte_row_last, bif_l.byte_data};
            if (hold && rst_n)
                chk("hold_stable", {21'd0, bif_m.byte_valid, act_m}, {21'd0, 1'b1, held});
            hold = rst_n && bif_m.byte_valid && !bif_m.byte_ready;
            held = act_m;
            if (rst_n && bif_m.byte_valid && bif_m.byte_ready) begin
                if (q_m.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_byte_msb: got 0x%0h, expected none", act_m);
                end else begin
                    e = q_m.pop_front();
                    chk("byte_msb", {22'd0, act_m}, {22'd0, e});
                end
            end
            if (rst_n && bif_l.byte_valid && bif_l.byte_ready) begin
                if (q_l.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_byte_lsb: got 0x%0h, expected none", act_l);
                end else begin
                    e = q_l.pop_front();
                    chk("byte_lsb", {22'd0, act_l}, {22'd0, e});
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic p, input logic fs);
        bif_m.pixel_valid = 1'b1;
        bif_m.pixel_in    = p;
        bif_m.frame_start = fs;
        step();
        bif_m.pixel_valid = 1'b0;
        bif_m.pixel_in    = 1'b0;
        bif_m.frame_start = 1'b0;
    endtask

    task automatic send_row(input logic [9:0] pat);
        for (int i = 0; i < W; i++) pix(pat[9-i], 1'b0);
    endtask

    task automatic fstart();
        bif_m.frame_start = 1'b1;
        step();
        bif_m.frame_start = 1'b0;
    endtask

    task automatic drain(input string name);
        bif_m.byte_ready = 1'b1;
        for (int i = 0; i < 40 && bif_m.byte_valid; i++) step();
        chk({name, "_drained"}, {31'd0, bif_m.byte_valid}, 32'd0);
        chk({name, "_q_msb_left"}, q_m.size(), 32'd0);
        chk({name, "_q_lsb_left"}, q_l.size(), 32'd0);
    endtask

    localparam logic [9:0] ROW_A = 10'b1111111111;
    localparam logic [9:0] ROW_B = 10'b1100110011;

    initial begin
        bif_m.frame_start = 1'b0;
        bif_m.pixel_valid = 1'b0;
        bif_m.pixel_in    = 1'b0;
        bif_m.byte_ready  = 1'b0;
        fork
            monitor();
        join_none

        // reset state
        step();
        step();
        chk("rst_valid", {31'd0, bif_m.byte_valid}, 32'd0);
        chk("rst_data", {24'd0, bif_m.byte_data}, 32'd0);
        chk("rst_tags", {30'd0, bif_m.byte_frame_last, bif_m.byte_row_last}, 32'd0);
        chk("rst_ovf", {31'd0, bif_m.overflow}, 32'd0);
        rst_n = 1'b1;
        step();

        // alternating pixels, two rows, ready high
        bif_m.byte_ready = 1'b1;
        for (int r = 0; r < H; r++) begin
            for (int i = 0; i < W; i++) begin
                if (i == 7) expect_b(8'hAA, 8'h55, 1'b0, 1'b0);
                if (i == 9) expect_b(8'h80, 8'h01, 1'b1, (r == 1));
                pix((i % 2) == 0, 1'b0);
                if (r == 0 && i == 6) chk("lat_before_8th", {31'd0, bif_m.byte_valid}, 32'd0);
                if (r == 0 && i == 7) chk("lat_after_8th", {31'd0, bif_m.byte_valid}, 32'd1);
            end
        end
        drain("alt");

        // all-ones frame: row-end partial byte zero-padded
        expect_b(8'hFF, 8'hFF, 1'b0, 1'b0);
        expect_b(8'hC0, 8'h03, 1'b1, 1'b0);
        expect_b(8'hFF, 8'hFF, 1'b0, 1'b0);
        expect_b(8'hC0, 8'h03, 1'b1, 1'b1);
        send_row(ROW_A);
        send_row(ROW_A);
        drain("ones");

        // consumer stalled: 4 bytes held, bytes 5 and 6 dropped
        bif_m.byte_ready = 1'b0;
        fstart();
        expect_b(8'hFF, 8'hFF, 1'b0, 1'b0);
        expect_b(8'hC0, 8'h03, 1'b1, 1'b0);
        expect_b(8'hFF, 8'hFF, 1'b0, 1'b0);
        expect_b(8'hC0, 8'h03, 1'b1, 1'b1);
        for (int k = 0; k < 30; k++) begin
            pix(1'b1, 1'b0);
            if (k == 26) chk("ovf_before_drop", {31'd0, bif_m.overflow}, 32'd0);
            if (k == 27) chk("ovf_after_drop", {31'd0, bif_m.overflow}, 32'd1);
        end
        drain("stall");
        chk("ovf_sticky", {31'd0, bif_m.overflow}, 32'd1);
        chk("ovf_sticky_lsb", {31'd0, bif_l.overflow}, 32'd1);
        fstart();
        chk("ovf_cleared_fs", {31'd0, bif_m.overflow}, 32'd0);

        // full FIFO with push and pop on the same edge
        bif_m.byte_ready = 1'b0;
        expect_b(8'hFF, 8'hFF, 1'b0, 1'b0);
        expect_b(8'hC0, 8'h03, 1'b1, 1'b0);
        expect_b(8'hCC, 8'h33, 1'b0, 1'b0);
        expect_b(8'hC0, 8'h03, 1'b1, 1'b1);
        expect_b(8'hFF, 8'hFF, 1'b0, 1'b0);
        expect_b(8'hC0, 8'h03, 1'b1, 1'b0);
        send_row(ROW_A);
        send_row(ROW_B);
        for (int i = 0; i < W; i++) begin
            if (i == 7) bif_m.byte_ready = 1'b1;
            pix(ROW_A[9-i], 1'b0);
        end
        chk("ovf_push_pop_full", {31'd0, bif_m.overflow}, 32'd0);
        drain("pushpop");

        // frame_start mid-row discards the partial byte; queued bytes drain first
        bif_m.byte_ready = 1'b0;
        fstart();
        expect_b(8'hFF, 8'hFF, 1'b0, 1'b0);
        expect_b(8'hC0, 8'h03, 1'b1, 1'b0);
        send_row(ROW_A);
        for (int k = 0; k < 3; k++) pix(1'b1, 1'b0);
        expect_b(8'hCC, 8'h33, 1'b0, 1'b0);
        expect_b(8'hC0, 8'h03, 1'b1, 1'b0);
        pix(ROW_B[9], 1'b1);
        for (int i = 1; i < W; i++) pix(ROW_B[9-i], 1'b0);
        chk("ovf_fs_restart", {31'd0, bif_m.overflow}, 32'd0);
        drain("restart");

        // reset with bytes queued, a partial byte pending and overflow set
        bif_m.byte_ready = 1'b0;
        send_row(ROW_A);
        send_row(ROW_B);
        send_row(ROW_A);
        for (int k = 0; k < 3; k++) pix(1'b1, 1'b0);
        chk("ovf_before_rst", {31'd0, bif_m.overflow}, 32'd1);
        rst_n = 1'b0;
        step();
        chk("rst2_valid", {31'd0, bif_m.byte_valid}, 32'd0);
        chk("rst2_ovf", {31'd0, bif_m.overflow}, 32'd0);
        chk("rst2_data", {24'd0, bif_m.byte_data}, 32'd0);
        rst_n = 1'b1;
        bif_m.byte_ready = 1'b1;
        expect_b(8'h80, 8'h01, 1'b0, 1'b0);
        expect_b(8'h00, 8'h00, 1'b1, 1'b0);
        send_row(10'b1000000000);
        drain("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
